// File: rtl/speech_pkg.sv
// Shared types and sizing helpers for the speech template matcher.
package speech_pkg;

  localparam int SAMPLE_W        = 8;
  localparam int DEF_N_SAMPLES   = 64;
  localparam int DEF_N_TEMPLATES = 4;
  localparam int DEF_ACC_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_COMPARE,
    ST_DRAIN,
    ST_EVAL,
    ST_DONE
  } match_state_t;

  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int tpl_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/speech_match_ctrl_sad_accum.sv
// Saturating sum-of-absolute-differences accumulator fed by a one-deep read pipeline.
module sad_accum
  import speech_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_clear,
  input  logic                i_issue,
  input  logic [SAMPLE_W-1:0] i_a,
  input  logic [SAMPLE_W-1:0] i_b,
  output logic [ACC_W-1:0]    o_acc
);

  logic                       r_valid;
  logic [ACC_W-1:0]           r_acc;
  logic signed [SAMPLE_W:0]   w_diff;
  logic [SAMPLE_W-1:0]        w_mag;
  logic [ACC_W:0]             w_sum;

  assign w_diff = $signed({1'b0, i_a}) - $signed({1'b0, i_b});
  assign w_mag  = w_diff[SAMPLE_W] ? SAMPLE_W'(-w_diff) : w_diff[SAMPLE_W-1:0];
  assign w_sum  = {1'b0, r_acc} + {{(ACC_W + 1 - SAMPLE_W){1'b0}}, w_mag};
  assign o_acc  = r_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_acc   <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_valid <= i_issue;
      // Clamp at all-ones instead of wrapping when the carry bit is set.
      if (r_valid) r_acc <= w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/speech_match_ctrl.sv
// Captures an audio window, scores it against every template by SAD and
// publishes the index and score of the closest template.
module speech_match_ctrl
  import speech_pkg::*;
#(
  parameter int  N_SAMPLES   = DEF_N_SAMPLES,
  parameter int  N_TEMPLATES = DEF_N_TEMPLATES,
  parameter int  ACC_W       = DEF_ACC_W,
  localparam int ADDR_W      = addr_w(N_SAMPLES),
  localparam int TPL_W       = tpl_w(N_TEMPLATES)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    sample_valid,
  input  logic [SAMPLE_W-1:0]     sample,
  output logic                    cap_we,
  output logic [ADDR_W-1:0]       cap_addr,
  output logic [SAMPLE_W-1:0]     cap_wdata,
  input  logic [SAMPLE_W-1:0]     cap_rdata,
  output logic [TPL_W+ADDR_W-1:0] tpl_addr,
  input  logic [SAMPLE_W-1:0]     tpl_rdata,
  output logic                    busy,
  output logic                    done,
  output logic [TPL_W-1:0]        match_id,
  output logic [ACC_W-1:0]        match_score
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_SAMPLES - 1);
  localparam logic [TPL_W-1:0]  LAST_TPL = TPL_W'(N_TEMPLATES - 1);

  if (ACC_W < SAMPLE_W + ADDR_W) begin : g_acc_w_check
    $error("ACC_W is too narrow: a full-window SAD could saturate");
  end

  match_state_t      r_state;
  match_state_t      w_state_next;
  logic [ADDR_W-1:0] r_idx;
  logic [TPL_W-1:0]  r_tpl;
  logic [ACC_W-1:0]  r_best_score;
  logic [TPL_W-1:0]  r_best_id;
  logic              r_busy;
  logic              r_done;
  logic [TPL_W-1:0]  r_match_id;
  logic [ACC_W-1:0]  r_match_score;
  logic [ACC_W-1:0]  w_acc;
  logic              w_issue;
  logic              w_clear;
  logic              w_better;
  logic [TPL_W-1:0]  w_best_id;
  logic [ACC_W-1:0]  w_best_score;

  sad_accum #(.ACC_W(ACC_W)) u_sad (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_clear),
    .i_issue (w_issue),
    .i_a     (cap_rdata),
    .i_b     (tpl_rdata),
    .o_acc   (w_acc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (start) w_state_next = ST_CAPTURE;
        ST_CAPTURE: if (sample_valid && r_idx == LAST_IDX) w_state_next = ST_COMPARE;
        ST_COMPARE: if (r_idx == LAST_IDX) w_state_next = ST_DRAIN;
        ST_DRAIN:   w_state_next = ST_EVAL;
        ST_EVAL:    w_state_next = (r_tpl == LAST_TPL) ? ST_DONE : ST_COMPARE;
        ST_DONE:    w_state_next = ST_IDLE;
        default:    w_state_next = ST_IDLE;
      endcase
    end
  end

  // The accumulator is held only while reads are in flight; it is zeroed everywhere else.
  always_comb begin
    cap_we    = 1'b0;
    cap_wdata = '0;
    w_issue   = 1'b0;
    w_clear   = 1'b1;
    case (r_state)
      ST_CAPTURE: begin
        cap_we    = sample_valid;
        cap_wdata = sample;
      end
      ST_COMPARE: begin
        w_issue = 1'b1;
        w_clear = abort;
      end
      ST_DRAIN: w_clear = abort;
      default: ;
    endcase
  end

  assign w_better     = (w_acc < r_best_score);
  assign w_best_id    = w_better ? r_tpl : r_best_id;
  assign w_best_score = w_better ? w_acc : r_best_score;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx         <= '0;
      r_tpl         <= '0;
      r_best_score  <= '0;
      r_best_id     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_match_id    <= '0;
      r_match_score <= '0;
    end else begin
      r_busy <= (w_state_next != ST_IDLE);
      r_done <= (w_state_next == ST_DONE);
      if (abort || r_state == ST_IDLE) begin
        r_idx        <= '0;
        r_tpl        <= '0;
        r_best_score <= '1;
        r_best_id    <= '0;
      end else begin
        case (r_state)
          ST_CAPTURE: if (sample_valid) r_idx <= r_idx + 1'b1;
          ST_COMPARE: r_idx <= r_idx + 1'b1;
          ST_EVAL: begin
            r_best_id    <= w_best_id;
            r_best_score <= w_best_score;
            r_idx        <= '0;
            if (r_tpl != LAST_TPL) r_tpl <= r_tpl + 1'b1;
          end
          default: ;
        endcase
      end
      // Result is published on the same edge that enters DONE, so it lines up with done.
      if (w_state_next == ST_DONE) begin
        r_match_id    <= w_best_id;
        r_match_score <= w_best_score;
      end
    end
  end

  assign cap_addr    = r_idx;
  assign tpl_addr    = {r_tpl, r_idx};
  assign busy        = r_busy;
  assign done        = r_done;
  assign match_id    = r_match_id;
  assign match_score = r_match_score;

endmodule

// File: tb/tb_speech_match_ctrl.sv
// Directed bench for speech_match_ctrl with behavioural capture RAM and template ROM.
module tb_speech_match_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        sample_valid = 1'b0;
  logic [7:0]  sample = 8'h00;
  logic        cap_we;
  logic [5:0]  cap_addr;
  logic [7:0]  cap_wdata;
  logic [7:0]  cap_rdata;
  logic [7:0]  tpl_addr;
  logic [7:0]  tpl_rdata;
  logic        busy;
  logic        done;
  logic [1:0]  match_id;
  logic [15:0] match_score;

  logic [7:0] cap_mem [0:63];
  logic [7:0] tpl_mem [0:255];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  speech_match_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .sample_valid (sample_valid),
    .sample       (sample),
    .cap_we       (cap_we),
    .cap_addr     (cap_addr),
    .cap_wdata    (cap_wdata),
    .cap_rdata    (cap_rdata),
    .tpl_addr     (tpl_addr),
    .tpl_rdata    (tpl_rdata),
    .busy         (busy),
    .done         (done),
    .match_id     (match_id),
    .match_score  (match_score)
  );

  always @(posedge clk) begin
    if (cap_we) cap_mem[cap_addr] <= cap_wdata;
    cap_rdata <= cap_mem[cap_addr];
    tpl_rdata <= tpl_mem[tpl_addr];
  end

  task automatic set_tpl(input logic [7:0] v0, input logic [7:0] v1,
                         input logic [7:0] v2, input logic [7:0] v3);
    for (int i = 0; i < 64; i++) begin
      tpl_mem[i]       = v0;
      tpl_mem[64 + i]  = v1;
      tpl_mem[128 + i] = v2;
      tpl_mem[192 + i] = v3;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Writes n bytes of value v, one every other cycle; counts wrong write-port cycles.
  task automatic capture(input logic [7:0] v, input int n, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); sample_valid = 1'b1; sample = v;
      #1;
      if (cap_we !== 1'b1 || cap_addr !== 6'(i) || cap_wdata !== v) bad++;
      @(negedge clk); sample_valid = 1'b0;
    end
  endtask

  // Runs 300 cycles from the cycle after the last capture write, observing the DUT.
  task automatic run_window(input bit disturb, output int lat, output int ndone, output int nwe,
                            output logic busy_mid, output logic [1:0] id_mid,
                            output logic [15:0] sc_mid, output logic busy_end);
    lat = -1; ndone = 0; nwe = 0;
    busy_mid = 1'b0; id_mid = '0; sc_mid = '0; busy_end = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      if (k == 100) begin busy_mid = busy; id_mid = match_id; sc_mid = match_score; end
      if (k == 300) busy_end = busy;
      if (disturb) begin
        if (k == 10 || k == 150) begin start = 1'b1; sample_valid = 1'b1; sample = 8'hAA; end
        else begin start = 1'b0; sample_valid = 1'b0; end
      end
      #1;
      if (cap_we !== 1'b0) nwe++;
    end
    start = 1'b0; sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0d, expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0d, expected 0", done); end
    tests++; if (match_id !== 2'd0 || match_score !== 16'd0) begin fails++;
      $display("FAIL reset_match: got id=%0d score=%0d, expected 0/0", match_id, match_score); end
    tests++; if (cap_we !== 1'b0 || cap_addr !== 6'd0 || cap_wdata !== 8'd0 || tpl_addr !== 8'd0) begin fails++;
      $display("FAIL reset_mem_ports: got we=%0d addr=%0d wdata=%0d taddr=%0d, expected all 0",
               cap_we, cap_addr, cap_wdata, tpl_addr); end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); sample_valid = 1'b1; sample = 8'h55;
    #1;
    tests++; if (cap_we !== 1'b0) begin fails++; $display("FAIL idle_drop_we: got %0d, expected 0", cap_we); end
    @(negedge clk); sample_valid = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_sv_busy: got %0d, expected 0", busy); end
    $display("[TB] reset: busy=%0d done=%0d id=%0d score=%0d", busy, done, match_id, match_score);
  endtask

  task automatic test_basic();
    int bad, lat, nd, nwe;
    logic bm, be;
    logic [1:0] im;
    logic [15:0] sm;
    set_tpl(8'h20, 8'h12, 8'h00, 8'hFF);
    pulse_start();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_start: got %0d, expected 1", busy); end
    capture(8'h10, 64, bad);
    tests++; if (bad !== 0) begin fails++; $display("FAIL basic_capture_port: got %0d bad writes, expected 0", bad); end
    run_window(1'b0, lat, nd, nwe, bm, im, sm, be);
    tests++; if (nd !== 1) begin fails++; $display("FAIL basic_done_count: got %0d, expected 1", nd); end
    tests++; if (lat !== 264) begin fails++; $display("FAIL basic_latency: got %0d, expected 264", lat); end
    tests++; if (match_id !== 2'd1) begin fails++; $display("FAIL basic_id: got %0d, expected 1", match_id); end
    tests++; if (match_score !== 16'd128) begin fails++; $display("FAIL basic_score: got %0d, expected 128", match_score); end
    tests++; if (bm !== 1'b1 || be !== 1'b0) begin fails++;
      $display("FAIL basic_busy: got mid=%0d end=%0d, expected 1/0", bm, be); end
    $display("[TB] basic: id=%0d score=%0d latency=%0d dones=%0d", match_id, match_score, lat, nd);
  endtask

  task automatic test_tie();
    int bad, lat, nd, nwe;
    logic bm, be;
    logic [1:0] im;
    logic [15:0] sm;
    set_tpl(8'h80, 8'h12, 8'h12, 8'hFF);
    pulse_start();
    capture(8'h10, 64, bad);
    run_window(1'b0, lat, nd, nwe, bm, im, sm, be);
    tests++; if (match_id !== 2'd1 || match_score !== 16'd128 || nd !== 1) begin fails++;
      $display("FAIL tie_result: got id=%0d score=%0d dones=%0d, expected 1/128/1", match_id, match_score, nd); end
    $display("[TB] tie: id=%0d score=%0d", match_id, match_score);
  endtask

  task automatic test_ignore();
    int bad, lat, nd, nwe;
    logic bm, be;
    logic [1:0] im;
    logic [15:0] sm;
    set_tpl(8'h00, 8'h40, 8'h11, 8'h20);
    pulse_start();
    capture(8'h10, 64, bad);
    run_window(1'b1, lat, nd, nwe, bm, im, sm, be);
    tests++; if (nwe !== 0) begin fails++; $display("FAIL ignore_cap_we: got %0d writes, expected 0", nwe); end
    tests++; if (nd !== 1 || lat !== 264) begin fails++;
      $display("FAIL ignore_done: got dones=%0d latency=%0d, expected 1/264", nd, lat); end
    tests++; if (match_id !== 2'd2 || match_score !== 16'd64) begin fails++;
      $display("FAIL ignore_result: got id=%0d score=%0d, expected 2/64", match_id, match_score); end
    $display("[TB] ignore: id=%0d score=%0d stray_we=%0d", match_id, match_score, nwe);
  endtask

  task automatic test_abort();
    int bad, lat, nd, nwe;
    logic bm, be;
    logic [1:0] im;
    logic [15:0] sm;
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_start_same_cycle: got busy=%0d, expected 0", busy); end
    pulse_start();
    capture(8'h10, 30, bad);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %0d, expected 0", busy); end
    nd = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    tests++; if (nd !== 0) begin fails++; $display("FAIL abort_no_done: got %0d dones, expected 0", nd); end
    tests++; if (match_id !== 2'd2 || match_score !== 16'd64) begin fails++;
      $display("FAIL abort_hold: got id=%0d score=%0d, expected 2/64", match_id, match_score); end
    set_tpl(8'h20, 8'h12, 8'h00, 8'hFF);
    pulse_start();
    capture(8'h10, 64, bad);
    tests++; if (bad !== 0) begin fails++; $display("FAIL abort_recapture_port: got %0d bad writes, expected 0", bad); end
    run_window(1'b0, lat, nd, nwe, bm, im, sm, be);
    tests++; if (im !== 2'd2 || sm !== 16'd64) begin fails++;
      $display("FAIL abort_hold_during_run: got id=%0d score=%0d, expected 2/64", im, sm); end
    tests++; if (match_id !== 2'd1 || match_score !== 16'd128 || nd !== 1) begin fails++;
      $display("FAIL abort_rerun: got id=%0d score=%0d dones=%0d, expected 1/128/1", match_id, match_score, nd); end
    $display("[TB] abort: rerun id=%0d score=%0d", match_id, match_score);
  endtask

  task automatic test_async_reset();
    int bad, nd;
    set_tpl(8'h00, 8'h40, 8'h11, 8'h20);
    pulse_start();
    capture(8'h10, 64, bad);
    repeat (50) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++;
      $display("FAIL areset_ctrl: got busy=%0d done=%0d, expected 0/0", busy, done); end
    tests++; if (match_id !== 2'd0 || match_score !== 16'd0) begin fails++;
      $display("FAIL areset_match: got id=%0d score=%0d, expected 0/0", match_id, match_score); end
    tests++; if (cap_we !== 1'b0 || cap_addr !== 6'd0 || cap_wdata !== 8'd0 || tpl_addr !== 8'd0) begin fails++;
      $display("FAIL areset_ports: got we=%0d addr=%0d wdata=%0d taddr=%0d, expected all 0",
               cap_we, cap_addr, cap_wdata, tpl_addr); end
    @(negedge clk); reset_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    tests++; if (nd !== 0 || busy !== 1'b0) begin fails++;
      $display("FAIL areset_after: got dones=%0d busy=%0d, expected 0/0", nd, busy); end
    $display("[TB] async_reset: dones_after=%0d busy=%0d", nd, busy);
  endtask

  task automatic test_saturation();
    int bad, lat, nd, nwe;
    logic bm, be;
    logic [1:0] im;
    logic [15:0] sm;
    set_tpl(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    pulse_start();
    capture(8'h00, 64, bad);
    run_window(1'b0, lat, nd, nwe, bm, im, sm, be);
    tests++; if (match_score !== 16'd16320) begin fails++; $display("FAIL extreme_score: got %0d, expected 16320", match_score); end
    tests++; if (match_id !== 2'd0) begin fails++; $display("FAIL extreme_id: got %0d, expected 0", match_id); end
    tests++; if (nd !== 1 || lat !== 264) begin fails++;
      $display("FAIL extreme_done: got dones=%0d latency=%0d, expected 1/264", nd, lat); end
    $display("[TB] extreme: id=%0d score=%0d", match_id, match_score);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_ignore();
    test_abort();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/speech_match_ctrl.md
Name: speech_match_ctrl

Overview:
- Sequencer for the speech-recognition datapath. On `start` it captures a fixed-length window of 8-bit audio samples from the SPI receiver into a capture RAM.
- It then replays the window against each stored template in a template ROM, accumulating the sum of absolute differences (SAD) per template.
- It reports the best-matching template index and its score.
- Sits between the SPI receive path (already synchronized into the `clk` domain) and the LED/result logic.

Parameters:
- N_SAMPLES, 64, samples per capture window and per template (power of 2, ≥2).
- N_TEMPLATES, 4, number of stored templates (≥1).
- ACC_W, 16, SAD accumulator and score width.
- Derived: ADDR_W = clog2(N_SAMPLES), TPL_W = max(1, clog2(N_TEMPLATES)).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins capture when idle.
- abort  in  1  synchronous cancel; returns to IDLE with no `done`.
- sample_valid  in  1  one-cycle pulse per received byte, already in `clk` domain.
- sample  in  8  unsigned audio byte, valid with `sample_valid`.
- cap_we  out  1  capture RAM write enable.
- cap_addr  out  ADDR_W  capture RAM address, used for both write and read.
- cap_wdata  out  8  capture RAM write data.
- cap_rdata  in  8  capture RAM read data, valid 1 cycle after `cap_addr`.
- tpl_addr  out  TPL_W+ADDR_W  template ROM address {template index, sample index}.
- tpl_rdata  in  8  template ROM data, valid 1 cycle after `tpl_addr`.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a result is published.
- match_id  out  TPL_W  index of the best template.
- match_score  out  ACC_W  SAD of the best template.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All counters, accumulator and best register cleared.
  - cap_we=0, cap_addr=0, cap_wdata=0, tpl_addr=0.
  - busy=0, done=0, match_id=0, match_score=0.
  - Reset mid-operation discards all progress; no `done`.
- States: IDLE, CAPTURE, COMPARE, DRAIN, EVAL, DONE.
- IDLE:
  - `start` → CAPTURE.
  - Sample index i=0; best score = all ones; best id = 0.
  - `sample_valid` is ignored.
- CAPTURE:
  - Each `sample_valid` pulse: same cycle, cap_we=1, cap_addr=i, cap_wdata=sample (combinational from inputs); then i increments.
  - On the write with i=N_SAMPLES-1: i←0, template t←0, accumulator←0, → COMPARE.
  - No timeout.
- COMPARE:
  - One read per cycle: cap_addr=i, tpl_addr={t,i}; i increments.
  - Pipeline valid bit set one cycle after each issue; while it is set, acc ← acc + |cap_rdata − tpl_rdata|.
  - The difference is 9-bit signed, magnitude 8-bit.
  - Accumulation saturates at 2^ACC_W−1.
  - After issuing i=N_SAMPLES-1 → DRAIN.
- DRAIN: one cycle; last returned pair accumulated; → EVAL.
- EVAL:
  - If acc < best score (strict), best←{t, acc}. Ties keep the lower index.
  - Then acc←0, i←0.
  - If t=N_TEMPLATES-1 → DONE; else t++ → COMPARE.
- DONE:
  - match_id/match_score ← best; done=1 for this cycle only; → IDLE.
  - Outputs hold until the next DONE or reset.
- Timing:
  - Per template: N_SAMPLES+2 cycles.
  - `done` is asserted N_TEMPLATES·(N_SAMPLES+2) cycles after the cycle of the last capture write.
- Event rules:
  - `start` while busy is ignored.
  - `sample_valid` outside CAPTURE is dropped; cap_we stays 0.
  - `abort` has priority over every transition, including DONE: → IDLE, done stays 0, match_* unchanged.
  - Simultaneous `start` and `abort` in IDLE: abort wins; stay IDLE.
- Width check: a static assertion fires if ACC_W < 8+ADDR_W, since saturation then becomes reachable.
- busy is registered from state; cap_* and tpl_addr are registered except cap_we/cap_wdata in CAPTURE.

Decomposition:
- Shared package speech_pkg:
  - state enum `match_state_t`.
  - SAMPLE_W=8 constant.
  - Default N_SAMPLES/N_TEMPLATES/ACC_W constants.
  - `clog2`-derived width functions.
- One sub-module: `sad_accum`. It holds the pipeline valid bit, the absolute difference, the saturating accumulate and a clear input.
- The FSM and counters stay in speech_match_ctrl.

Test Plan:
- Basic match:
  - Stimulus: defaults; capture 64 × 0x10; template0 all 0x20, template1 all 0x12, template2 all 0x00, template3 all 0xFF.
  - Response: done once, match_id=1, match_score=128; done 264 cycles after the last write.
- Tie:
  - Stimulus: template1 and template2 both all 0x12 (template0 and template3 distant).
  - Response: match_id=1, score=128.
- Ignore rules:
  - Stimulus: `start` and `sample_valid` pulses during COMPARE.
  - Response: no cap_we, no restart, result unchanged versus the undisturbed run.
- Abort:
  - Stimulus: abort after 30 capture writes; then a fresh start with full capture.
  - Response: no done after the abort; the second run yields the correct result; prior match_* held meanwhile.
- Async reset:
  - Stimulus: reset_n=0 mid-COMPARE, asynchronous to clk.
  - Response: all outputs 0 immediately; busy=0; no done after release.
- Saturation and extremes:
  - Stimulus: ACC_W=16; capture all 0x00; all templates 0xFF.
  - Response: score=16320, match_id=0, no overflow wrap.
